accum_xcel_gen: RTL and testbench
=================================

# accum_xcel_gen

Parametrised memory-reduction accelerator: on `go` it streams `size` words from memory starting at `base_addr`, reduces them under a selectable mode (wrapping sum, saturating sum, max, min), and returns the result over a val/rdy port. It is the next-generation accumulator accelerator. It merges control and datapath into one block with full val/rdy memory request handshake and pipelined in-order responses. It sits between the processor's accelerator I/O interface and the data-memory port.

## Interface
- `DATA_W`, 32, data and result width
- `ADDR_W`, 16, byte address width
- `SIZE_W`, 8, element-count width (max `2^SIZE_W-1` elements)
- `STRIDE`, 4, byte increment between consecutive elements
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `go`  in  1  start pulse, honoured only in IDLE
- `base_addr`  in  ADDR_W  first element address, latched on accepted `go`
- `size`  in  SIZE_W  element count, latched on accepted `go`
- `mode`  in  2  00 wrap sum, 01 unsigned saturating sum, 10 unsigned max, 11 unsigned min; latched on `go`
- `busy`  out  1  high in RUN and DONE
- `memreq_val`  out  1  read request valid
- `memreq_rdy`  in  1  memory accepts request
- `memreq_addr`  out  ADDR_W  request address
- `memresp_val`  in  1  read data valid (in order, no backpressure)
- `memresp_data`  in  DATA_W  read data
- `result_val`  out  1  result valid
- `result_rdy`  in  1  consumer accepts result
- `result`  out  DATA_W  reduction result

## Operation
- FSM states: IDLE, RUN, DONE. The state register is a reset-to-IDLE register. Next-state logic and output logic are combinational.
- IDLE: if `go`, latch `base_addr`/`size`/`mode`, load `acc` with the identity value (0 for sum/max, all-ones for min), and clear `req_cnt` and `resp_cnt`. Go to RUN, or go straight to DONE if `size==0`.
- RUN:
  - `memreq_val = (req_cnt != size_q)`; `memreq_addr = base_q + req_cnt*STRIDE`, computed mod `2^ADDR_W`.
  - A request handshake (`memreq_val & memreq_rdy`) increments `req_cnt`.
  - Each `memresp_val` updates `acc` and increments `resp_cnt`.
  - When the response that makes `resp_cnt == size_q` arrives, go to DONE.
- Update rules, with `d = memresp_data`:
  - Wrap sum: `acc + d` mod `2^DATA_W`.
  - Saturating sum: the unsigned sum, clamped to all-ones on carry-out.
  - Max: larger of `acc` and `d` (unsigned).
  - Min: smaller of `acc` and `d` (unsigned).
- DONE: `result_val=1` and `result=acc`, held stable. On `result_val & result_rdy`, go to IDLE.
- `go` in RUN or DONE is ignored. `memresp_val` in IDLE or DONE is ignored and has no state effect.
- Counters are `SIZE_W+1` bits wide internally, so `size = 2^SIZE_W-1` cannot overflow.

## Timing
- Reset values: state IDLE; `busy`, `memreq_val`, and `result_val` are 0; `memreq_addr` is 0; `result` is 0; `acc` and the counters are 0.
- `rst` overrides everything, including mid-RUN. Outstanding responses arriving after reset land in IDLE and are ignored.
- `go` high at cycle t in IDLE: `busy` rises at t+1, and `memreq_val` is high at t+1 with `memreq_addr = base_addr`.
- Requests issue back-to-back, one per cycle, while `memreq_rdy=1`. With `memreq_rdy=0`, `memreq_val` and `memreq_addr` are held unchanged.
- A response can arrive in the same cycle as a request handshake; both counters update independently.
- Result latency: DONE is entered on the edge after the last response, so `result_val` rises one cycle after the final `memresp_val`.
- For `size=0`, `result_val` rises at t+1 with the identity value.
- After a result handshake at cycle u, the block is in IDLE at u+1, where `busy=0` and a new `go` is accepted.
- With `result_rdy=0`, the block stays in DONE indefinitely with outputs stable.

## Test plan
- **Wrap sum, 4 elements.** Stimulus: `base=0x100`, `size=4`, `mode=00`, `memreq_rdy=1`, memory words 1,2,3,4 returned 1 cycle after each request. Required:
  - Request addresses are 0x100, 0x104, 0x108, 0x10C on consecutive cycles.
  - `result=10`, with `result_val` one cycle after the last response.
- **Saturating sum vs wrap sum.** Data 0xFFFFFFF0, 0x20:
  - `mode=01` gives `result=0xFFFFFFFF`.
  - `mode=00` gives `result=0x10`.
- **Max and min.** Data 5, 0x80000000, 7:
  - `mode=10` gives 0x80000000.
  - `mode=11` gives 5.
- **Size zero.** `go` with `size=0` in each mode: no `memreq_val` ever; `result_val` at t+1 with `result` = 0, 0, 0, 0xFFFFFFFF respectively.
- **Backpressure.** `memreq_rdy` toggles 0/1 and responses are delayed 3 cycles (two outstanding). Required: `memreq_addr` stable while stalled, exactly `size` requests issued, correct sum. `result_rdy` held low 5 cycles: `result_val` and `result` stay stable, and a `go` pulsed during that time is ignored.
- **Reset mid-operation.** `rst` asserted after 2 of 4 responses. Required: next cycle all outputs are at reset values, late responses are ignored, and a fresh `go` produces the correct result.

Source files
------------

// File: rtl/accum_xcel_gen.sv
// accum_xcel_gen: streams size words from memory and reduces them (wrap/sat sum, max, min), result over val/rdy
module accum_xcel_gen #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int SIZE_W = 8,
  parameter int STRIDE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [SIZE_W-1:0] size,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              memreq_val,
  input  logic              memreq_rdy,
  output logic [ADDR_W-1:0] memreq_addr,
  input  logic              memresp_val,
  input  logic [DATA_W-1:0] memresp_data,
  output logic              result_val,
  input  logic              result_rdy,
  output logic [DATA_W-1:0] result
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [SIZE_W:0] size_q, size_d, req_cnt_q, req_cnt_d, resp_cnt_q, resp_cnt_d;
  logic [1:0] mode_q, mode_d;
  logic [DATA_W-1:0] acc_q, acc_d, upd;
  logic [DATA_W:0] sum;
  assign busy        = state_q != IDLE;
  assign memreq_val  = state_q == RUN && req_cnt_q != size_q;
  assign memreq_addr = state_q == RUN ? base_q + ADDR_W'(req_cnt_q) * ADDR_W'(STRIDE) : '0;
  assign result_val  = state_q == DONE;
  assign result      = result_val ? acc_q : '0;
  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, memresp_data};
    upd = mode_q == 2'b00 ? sum[DATA_W-1:0] :
          mode_q == 2'b01 ? (sum[DATA_W] ? '1 : sum[DATA_W-1:0]) :
          mode_q == 2'b10 ? (memresp_data > acc_q ? memresp_data : acc_q) :
                            (memresp_data < acc_q ? memresp_data : acc_q);
  end
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    size_d     = size_q;
    mode_d     = mode_q;
    acc_d      = acc_q;
    req_cnt_d  = req_cnt_q;
    resp_cnt_d = resp_cnt_q;
    if (state_q == IDLE && go) begin
      base_d     = base_addr;
      size_d     = {1'b0, size};
      mode_d     = mode;
      acc_d      = mode == 2'b11 ? '1 : '0;
      req_cnt_d  = '0;
      resp_cnt_d = '0;
      state_d    = size == '0 ? DONE : RUN;
    end
    if (state_q == RUN) begin
      if (memreq_val && memreq_rdy) req_cnt_d = req_cnt_q + 1'b1;
      if (memresp_val) begin
        acc_d      = upd;
        resp_cnt_d = resp_cnt_q + 1'b1;
        if (resp_cnt_d == size_q) state_d = DONE;
      end
    end
    if (state_q == DONE && result_rdy) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      size_q     <= '0;
      mode_q     <= '0;
      acc_q      <= '0;
      req_cnt_q  <= '0;
      resp_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      size_q     <= size_d;
      mode_q     <= mode_d;
      acc_q      <= acc_d;
      req_cnt_q  <= req_cnt_d;
      resp_cnt_q <= resp_cnt_d;
    end
  end
endmodule

// File: tb/tb_accum_xcel_gen.sv
// tb_accum_xcel_gen: scoreboard bench with a delayed-response memory model and stall monitor
module tb_accum_xcel_gen;
  logic clk, rst, go, result_rdy;
  logic [15:0] base_addr;
  logic [7:0] size;
  logic [1:0] mode;
  logic memreq_rdy = 1'b1, memresp_val = 1'b0;
  logic [31:0] memresp_data = '0;
  logic busy, memreq_val, result_val;
  logic [15:0] memreq_addr;
  logic [31:0] result;
  int cyc = 0, pass_cnt = 0, total_cnt = 0, lat = 1, resp_seen = 0, last_resp_cyc = 0;
  bit tog = 0, stall_prev = 0;
  logic [15:0] stall_addr = '0;
  logic [31:0] mem [0:255];
  typedef struct {int due; logic [31:0] data;} resp_t;
  resp_t pend[$];
  resp_t r;
  logic [15:0] req_addr_q[$];
  int req_cyc_q[$];
  logic [31:0] exp_q[$];

  accum_xcel_gen dut (
    .clk(clk), .rst(rst), .go(go), .base_addr(base_addr), .size(size), .mode(mode),
    .busy(busy), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_addr(memreq_addr),
    .memresp_val(memresp_val), .memresp_data(memresp_data),
    .result_val(result_val), .result_rdy(result_rdy), .result(result)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: in-order responses lat cycles after each accepted request
  always @(negedge clk) begin
    memreq_rdy = tog ? cyc[0] : 1'b1;
    if (stall_prev && !rst) begin
      total_cnt++;
      if (memreq_val !== 1'b1 || memreq_addr !== stall_addr)
        $display("FAIL stall_hold val=%0b addr=%h want 1/%h", memreq_val, memreq_addr, stall_addr);
      else pass_cnt++;
    end
    stall_prev = memreq_val && !memreq_rdy;
    stall_addr = memreq_addr;
    memresp_val = 1'b0;
    memresp_data = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      memresp_val = 1'b1;
      memresp_data = r.data;
      resp_seen++;
      last_resp_cyc = cyc;
    end
    if (memreq_val && memreq_rdy) begin
      r.due = cyc + lat;
      r.data = mem[memreq_addr[9:2]];
      pend.push_back(r);
      req_addr_q.push_back(memreq_addr);
      req_cyc_q.push_back(cyc);
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic run_op(input logic [15:0] b, input logic [7:0] n, input logic [1:0] m,
                        input logic [31:0] e, input int l, input bit tg, input int hold, input string nm);
    int t0, w;
    logic [31:0] r0, exp_r;
    logic [15:0] ea;
    lat = l; tog = tg;
    req_addr_q.delete(); req_cyc_q.delete();
    exp_q.push_back(e);
    base_addr = b; size = n; mode = m; go = 1; t0 = cyc;
    tick;
    go = 0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL %s busy_rise got %0b want 1", nm, busy); else pass_cnt++;
    total_cnt++;
    if (n == 0) begin
      if (memreq_val !== 1'b0 || result_val !== 1'b1)
        $display("FAIL %s zero_size memreq_val=%0b result_val=%0b want 0/1", nm, memreq_val, result_val);
      else pass_cnt++;
    end else begin
      if (memreq_val !== 1'b1 || memreq_addr !== b)
        $display("FAIL %s first_req val=%0b addr=%h want 1/%h", nm, memreq_val, memreq_addr, b);
      else pass_cnt++;
    end
    w = 0;
    while (result_val !== 1'b1 && w < 300) begin tick; w++; end
    total_cnt++;
    if (result_val !== 1'b1) begin
      $display("FAIL %s timeout result_val=%0b want 1", nm, result_val);
      exp_r = exp_q.pop_front();
      return;
    end
    pass_cnt++;
    if (n != 0) begin
      total_cnt++;
      if (cyc !== last_resp_cyc + 1)
        $display("FAIL %s result_latency cyc=%0d want %0d", nm, cyc, last_resp_cyc + 1);
      else pass_cnt++;
    end
    r0 = result;
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin go = 1; base_addr = 16'h0600; size = 8'd3; mode = 2'b00; end
      tick;
      go = 0;
      total_cnt++;
      if (result_val !== 1'b1 || result !== r0)
        $display("FAIL %s hold_stable val=%0b result=%h want 1/%h", nm, result_val, result, r0);
      else pass_cnt++;
    end
    exp_r = exp_q.pop_front();
    total_cnt++;
    if (result !== exp_r) $display("FAIL %s result got %h want %h", nm, result, exp_r); else pass_cnt++;
    result_rdy = 1;
    tick;
    result_rdy = 0;
    total_cnt++;
    if (busy !== 1'b0 || result_val !== 1'b0)
      $display("FAIL %s after_handshake busy=%0b result_val=%0b want 0/0", nm, busy, result_val);
    else pass_cnt++;
    tick; tick;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL %s stays_idle busy=%0b want 0", nm, busy); else pass_cnt++;
    total_cnt++;
    if (req_addr_q.size() != int'(n))
      $display("FAIL %s req_count got %0d want %0d", nm, req_addr_q.size(), n);
    else pass_cnt++;
    for (int i = 0; i < req_addr_q.size(); i++) begin
      ea = b + 16'(4 * i);
      total_cnt++;
      if (req_addr_q[i] !== ea) $display("FAIL %s req_addr[%0d] got %h want %h", nm, i, req_addr_q[i], ea);
      else pass_cnt++;
      if (!tg) begin
        total_cnt++;
        if (req_cyc_q[i] != t0 + 1 + i)
          $display("FAIL %s req_cycle[%0d] got %0d want %0d", nm, i, req_cyc_q[i], t0 + 1 + i);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1; go = 0; result_rdy = 0; base_addr = '0; size = '0; mode = '0;
    tick; tick;
    total_cnt++;
    if (busy !== 1'b0 || memreq_val !== 1'b0 || memreq_addr !== 16'h0 || result_val !== 1'b0 || result !== 32'h0)
      $display("FAIL reset busy=%0b mv=%0b ma=%h rv=%0b res=%h want all 0", busy, memreq_val, memreq_addr, result_val, result);
    else pass_cnt++;
    rst = 0;
    tick;
  endtask

  task automatic test_wrap_sum;
    for (int i = 0; i < 4; i++) mem[8'h40 + i] = 32'(i + 1);
    run_op(16'h0100, 8'd4, 2'b00, 32'd10, 1, 0, 0, "wrap_sum");
  endtask

  task automatic test_sat_vs_wrap;
    mem[8'h80] = 32'hFFFF_FFF0;
    mem[8'h81] = 32'h0000_0020;
    run_op(16'h0200, 8'd2, 2'b01, 32'hFFFF_FFFF, 1, 0, 0, "sat_sum");
    run_op(16'h0200, 8'd2, 2'b00, 32'h0000_0010, 1, 0, 0, "wrap_carry");
  endtask

  task automatic test_max_min;
    mem[8'hC0] = 32'd5;
    mem[8'hC1] = 32'h8000_0000;
    mem[8'hC2] = 32'd7;
    run_op(16'h0300, 8'd3, 2'b10, 32'h8000_0000, 1, 0, 0, "max");
    run_op(16'h0300, 8'd3, 2'b11, 32'd5, 1, 0, 0, "min");
  endtask

  task automatic test_size_zero;
    for (int m = 0; m < 4; m++)
      run_op(16'h0700, 8'd0, 2'(m), m == 3 ? 32'hFFFF_FFFF : 32'h0, 1, 0, 0, "size_zero");
  endtask

  task automatic test_back_to_back_backpressure;
    for (int i = 0; i < 6; i++) mem[8'h00 + i] = 32'(10 * (i + 1));
    run_op(16'h0000, 8'd6, 2'b00, 32'd210, 3, 1, 5, "backpressure");
  endtask

  task automatic test_reset_mid;
    int r0, w;
    for (int i = 0; i < 4; i++) mem[8'h50 + i] = 32'(i + 1);
    lat = 3; tog = 0; r0 = resp_seen;
    base_addr = 16'h0140; size = 8'd4; mode = 2'b00; go = 1;
    tick;
    go = 0;
    w = 0;
    while (resp_seen - r0 < 2 && w < 50) begin tick; w++; end
    total_cnt++;
    if (resp_seen - r0 < 2) $display("FAIL reset_mid timeout responses=%0d want 2", resp_seen - r0); else pass_cnt++;
    rst = 1;
    tick;
    rst = 0;
    total_cnt++;
    if (busy !== 1'b0 || memreq_val !== 1'b0 || memreq_addr !== 16'h0 || result_val !== 1'b0 || result !== 32'h0)
      $display("FAIL reset_mid outputs busy=%0b mv=%0b ma=%h rv=%0b res=%h want all 0", busy, memreq_val, memreq_addr, result_val, result);
    else pass_cnt++;
    w = 0;
    while (pend.size() > 0 && w < 20) begin
      tick; w++;
      total_cnt++;
      if (busy !== 1'b0 || result_val !== 1'b0 || memreq_val !== 1'b0)
        $display("FAIL reset_mid late_resp busy=%0b rv=%0b mv=%0b want 0", busy, result_val, memreq_val);
      else pass_cnt++;
    end
    tick;
    run_op(16'h0140, 8'd4, 2'b00, 32'd10, 1, 0, 0, "reset_recover");
  endtask

  initial begin
    test_reset;
    test_wrap_sum;
    test_sat_vs_wrap;
    test_max_min;
    test_size_zero;
    test_back_to_back_backpressure;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
